bellek_eris: RTL and testbench



---
 rtl/bellek_eris_pkg.sv | 36 +++
 rtl/bib_hizalayici.sv | 42 ++++
 rtl/bellek_eris.sv | 194 +++++++++++++++++++
 tb/tb_bellek_eris.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bellek_eris_pkg.sv
// Shared definitions for the memory-access stage: size codes, writeback select codes,
// FSM state encodings, the writeback bundle, and the misalignment helper.
package bellek_eris_pkg;

    localparam logic [1:0] BOYUT_BAYT   = 2'b00;
    localparam logic [1:0] BOYUT_YARIM  = 2'b01;
    localparam logic [1:0] BOYUT_KELIME = 2'b10;

    localparam logic [1:0] GERIYAZ_ALU    = 2'b00;
    localparam logic [1:0] GERIYAZ_BELLEK = 2'b01;
    localparam logic [1:0] GERIYAZ_PC4    = 2'b10;

    typedef enum logic [1:0] {
        BOSTA = 2'b00,
        ISTEK = 2'b01,
        BEKLE = 2'b10
    } durum_e;

    // Everything geri_yaz consumes apart from the load value.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] deger;
        logic        yaz;
        logic [1:0]  sec;
        logic [31:0] pc;
    } gy_t;

    function automatic logic hizasiz(input logic [1:0] boyut, input logic [1:0] lsb);
        case (boyut)
            BOYUT_BAYT:  hizasiz = 1'b0;
            BOYUT_YARIM: hizasiz = lsb[0];
            default:     hizasiz = (lsb != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/bib_hizalayici.sv
// Byte-lane steering: store strobes and data replication on the way out,
// lane extraction and sign/zero extension on the way back in.
module bib_hizalayici
    import bellek_eris_pkg::*;
(
    input  logic [1:0]  boyut_i,
    input  logic [1:0]  adres_lsb_i,
    input  logic        isaretsiz_i,
    input  logic [31:0] yaz_veri_i,
    input  logic [31:0] okunan_veri_i,
    output logic [3:0]  maske_o,
    output logic [31:0] yaz_veri_o,
    output logic [31:0] bib_deger_o
);

    logic [7:0]  bayt;
    logic [15:0] yarim;

    assign bayt  = okunan_veri_i[{adres_lsb_i, 3'b000} +: 8];
    assign yarim = adres_lsb_i[1] ? okunan_veri_i[31:16] : okunan_veri_i[15:0];

    always_comb begin
        maske_o     = 4'b1111;
        yaz_veri_o  = yaz_veri_i;
        bib_deger_o = okunan_veri_i;
        case (boyut_i)
            BOYUT_BAYT: begin
                maske_o     = 4'b0001 << adres_lsb_i;
                yaz_veri_o  = {4{yaz_veri_i[7:0]}};
                bib_deger_o = isaretsiz_i ? {24'b0, bayt} : {{24{bayt[7]}}, bayt};
            end
            BOYUT_YARIM: begin
                // addr[0] is ignored: a half always lands on lanes 0-1 or 2-3.
                maske_o     = adres_lsb_i[1] ? 4'b1100 : 4'b0011;
                yaz_veri_o  = {2{yaz_veri_i[15:0]}};
                bib_deger_o = isaretsiz_i ? {16'b0, yarim} : {{16{yarim[15]}}, yarim};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bellek_eris.sv
// Memory-access pipeline stage: one request/response transaction per memory instruction,
// registered handoff to geri_yaz. BELLEK_HIZA_HATA_EN turns misaligned accesses into faults.
module bellek_eris
    import bellek_eris_pkg::*;
#(
    parameter int ADRES_BIT = 32,
    parameter int VERI_BIT  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 gecerli_i,
    input  logic                 bib_oku_i,
    input  logic                 bib_yaz_i,
    input  logic [1:0]           bib_boyut_i,
    input  logic                 bib_isaretsiz_i,
    input  logic [ADRES_BIT-1:0] bib_adres_i,
    input  logic [VERI_BIT-1:0]  bib_yaz_veri_i,
    input  logic [4:0]           rd_adres_i,
    input  logic [31:0]          rd_deger_i,
    input  logic                 yaz_yazmac_i,
    input  logic [1:0]           sec_geri_yaz_i,
    input  logic [31:0]          program_sayaci_artmis_i,
    output logic                 durdur_o,
    output logic                 bellek_istek_o,
    input  logic                 bellek_hazir_i,
    output logic                 bellek_yaz_o,
    output logic [ADRES_BIT-1:0] bellek_adres_o,
    output logic [VERI_BIT-1:0]  bellek_veri_o,
    output logic [3:0]           bellek_maske_o,
    input  logic                 bellek_yanit_gecerli_i,
    input  logic [VERI_BIT-1:0]  bellek_yanit_veri_i,
`ifdef BELLEK_HIZA_HATA_EN
    output logic                 hiza_hatasi_o,
    output logic [ADRES_BIT-1:0] hata_adres_o,
`endif
    output logic                 gecerli_o,
    output logic [4:0]           rd_adres_o,
    output logic [31:0]          rd_deger_o,
    output logic                 yaz_yazmac_o,
    output logic [1:0]           sec_geri_yaz_o,
    output logic [31:0]          program_sayaci_artmis_o,
    output logic [31:0]          bib_deger_o
);

    durum_e               durum_q, durum_d;
    gy_t                  gy_q, gy_d, cikis_q, cikis_d, gy_gelen;
    logic [ADRES_BIT-1:0] adres_q, adres_d;
    logic [1:0]           boyut_q, boyut_d;
    logic                 isaretsiz_q, isaretsiz_d;
    logic                 yaz_q, yaz_d;
    logic [31:0]          yaz_veri_q, yaz_veri_d;
    logic                 gecerli_q, gecerli_d;
    logic [31:0]          bib_q, bib_d;
    logic [3:0]           maske;
    logic [31:0]          cogul_veri, yuk_deger;
`ifdef BELLEK_HIZA_HATA_EN
    logic                 hiza_q, hiza_d;
    logic [ADRES_BIT-1:0] hata_adres_q, hata_adres_d;
`endif

    assign gy_gelen = '{rd: rd_adres_i, deger: rd_deger_i, yaz: yaz_yazmac_i,
                        sec: sec_geri_yaz_i, pc: program_sayaci_artmis_i};

    bib_hizalayici u_hiza (
        .boyut_i       (boyut_q),
        .adres_lsb_i   (adres_q[1:0]),
        .isaretsiz_i   (isaretsiz_q),
        .yaz_veri_i    (yaz_veri_q),
        .okunan_veri_i (bellek_yanit_veri_i),
        .maske_o       (maske),
        .yaz_veri_o    (cogul_veri),
        .bib_deger_o   (yuk_deger)
    );

    always_comb begin
        durum_d     = durum_q;
        gy_d        = gy_q;
        adres_d     = adres_q;
        boyut_d     = boyut_q;
        isaretsiz_d = isaretsiz_q;
        yaz_d       = yaz_q;
        yaz_veri_d  = yaz_veri_q;
        cikis_d     = cikis_q;
        bib_d       = bib_q;
        gecerli_d   = 1'b0;
`ifdef BELLEK_HIZA_HATA_EN
        hiza_d       = 1'b0;
        hata_adres_d = '0;
`endif
        case (durum_q)
            BOSTA: if (gecerli_i) begin
                gy_d        = gy_gelen;
                adres_d     = bib_adres_i;
                boyut_d     = bib_boyut_i;
                isaretsiz_d = bib_isaretsiz_i;
                yaz_d       = bib_yaz_i;
                yaz_veri_d  = bib_yaz_veri_i;
                if (bib_oku_i || bib_yaz_i) begin
`ifdef BELLEK_HIZA_HATA_EN
                    if (hizasiz(bib_boyut_i, bib_adres_i[1:0])) begin
                        cikis_d      = gy_gelen;
                        cikis_d.yaz  = 1'b0;
                        bib_d        = '0;
                        gecerli_d    = 1'b1;
                        hiza_d       = 1'b1;
                        hata_adres_d = bib_adres_i;
                    end else begin
                        durum_d = ISTEK;
                    end
`else
                    durum_d = ISTEK;
`endif
                end else begin
                    cikis_d   = gy_gelen;
                    bib_d     = '0;
                    gecerli_d = 1'b1;
                end
            end
            ISTEK: if (bellek_hazir_i) begin
                if (yaz_q) begin
                    cikis_d     = gy_q;
                    cikis_d.yaz = 1'b0;
                    bib_d       = '0;
                    gecerli_d   = 1'b1;
                    durum_d     = BOSTA;
                end else begin
                    durum_d = BEKLE;
                end
            end
            BEKLE: if (bellek_yanit_gecerli_i) begin
                cikis_d   = gy_q;
                bib_d     = yuk_deger;
                gecerli_d = 1'b1;
                durum_d   = BOSTA;
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q     <= BOSTA;
            gy_q        <= '0;
            adres_q     <= '0;
            boyut_q     <= '0;
            isaretsiz_q <= 1'b0;
            yaz_q       <= 1'b0;
            yaz_veri_q  <= '0;
            cikis_q     <= '0;
            bib_q       <= '0;
            gecerli_q   <= 1'b0;
`ifdef BELLEK_HIZA_HATA_EN
            hiza_q       <= 1'b0;
            hata_adres_q <= '0;
`endif
        end else begin
            durum_q     <= durum_d;
            gy_q        <= gy_d;
            adres_q     <= adres_d;
            boyut_q     <= boyut_d;
            isaretsiz_q <= isaretsiz_d;
            yaz_q       <= yaz_d;
            yaz_veri_q  <= yaz_veri_d;
            cikis_q     <= cikis_d;
            bib_q       <= bib_d;
            gecerli_q   <= gecerli_d;
`ifdef BELLEK_HIZA_HATA_EN
            hiza_q       <= hiza_d;
            hata_adres_q <= hata_adres_d;
`endif
        end
    end

    // Request fields are gated by the state so they read 0 whenever no request is pending.
    assign bellek_istek_o = (durum_q == ISTEK);
    assign durdur_o       = (durum_q != BOSTA);
    assign bellek_yaz_o   = bellek_istek_o & yaz_q;
    assign bellek_adres_o = bellek_istek_o ? {adres_q[ADRES_BIT-1:2], 2'b00} : '0;
    assign bellek_maske_o = bellek_istek_o ? maske : 4'b0000;
    assign bellek_veri_o  = bellek_istek_o ? cogul_veri : '0;

    assign gecerli_o               = gecerli_q;
    assign rd_adres_o              = cikis_q.rd;
    assign rd_deger_o              = cikis_q.deger;
    assign yaz_yazmac_o            = cikis_q.yaz;
    assign sec_geri_yaz_o          = cikis_q.sec;
    assign program_sayaci_artmis_o = cikis_q.pc;
    assign bib_deger_o             = bib_q;
`ifdef BELLEK_HIZA_HATA_EN
    assign hiza_hatasi_o = hiza_q;
    assign hata_adres_o  = hata_adres_q;
`endif

endmodule

// File: tb/tb_bellek_eris.sv
// Scoreboard bench for bellek_eris: directed instructions push expected geri_yaz bundles,
// a negedge monitor pops them whenever gecerli_o is seen.
module tb_bellek_eris;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        gecerli_i = 1'b0, bib_oku_i = 1'b0, bib_yaz_i = 1'b0, bib_isaretsiz_i = 1'b0;
    logic [1:0]  bib_boyut_i = '0, sec_geri_yaz_i = '0;
    logic [31:0] bib_adres_i = '0, bib_yaz_veri_i = '0, rd_deger_i = '0, program_sayaci_artmis_i = '0;
    logic [4:0]  rd_adres_i = '0;
    logic        yaz_yazmac_i = 1'b0;
    logic        durdur_o, bellek_istek_o, bellek_yaz_o, gecerli_o, yaz_yazmac_o;
    logic        bellek_hazir_i = 1'b0, bellek_yanit_gecerli_i = 1'b0;
    logic [31:0] bellek_adres_o, bellek_veri_o, bellek_yanit_veri_i = '0;
    logic [3:0]  bellek_maske_o;
    logic [4:0]  rd_adres_o;
    logic [31:0] rd_deger_o, program_sayaci_artmis_o, bib_deger_o;
    logic [1:0]  sec_geri_yaz_o;
`ifdef BELLEK_HIZA_HATA_EN
    logic        hiza_hatasi_o;
    logic [31:0] hata_adres_o;
`endif

    always #5 clk_i = ~clk_i;

    bellek_eris dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .gecerli_i(gecerli_i), .bib_oku_i(bib_oku_i),
        .bib_yaz_i(bib_yaz_i), .bib_boyut_i(bib_boyut_i), .bib_isaretsiz_i(bib_isaretsiz_i),
        .bib_adres_i(bib_adres_i), .bib_yaz_veri_i(bib_yaz_veri_i), .rd_adres_i(rd_adres_i),
        .rd_deger_i(rd_deger_i), .yaz_yazmac_i(yaz_yazmac_i), .sec_geri_yaz_i(sec_geri_yaz_i),
        .program_sayaci_artmis_i(program_sayaci_artmis_i), .durdur_o(durdur_o),
        .bellek_istek_o(bellek_istek_o), .bellek_hazir_i(bellek_hazir_i),
        .bellek_yaz_o(bellek_yaz_o), .bellek_adres_o(bellek_adres_o),
        .bellek_veri_o(bellek_veri_o), .bellek_maske_o(bellek_maske_o),
        .bellek_yanit_gecerli_i(bellek_yanit_gecerli_i), .bellek_yanit_veri_i(bellek_yanit_veri_i),
`ifdef BELLEK_HIZA_HATA_EN
        .hiza_hatasi_o(hiza_hatasi_o), .hata_adres_o(hata_adres_o),
`endif
        .gecerli_o(gecerli_o), .rd_adres_o(rd_adres_o), .rd_deger_o(rd_deger_o),
        .yaz_yazmac_o(yaz_yazmac_o), .sec_geri_yaz_o(sec_geri_yaz_o),
        .program_sayaci_artmis_o(program_sayaci_artmis_o), .bib_deger_o(bib_deger_o)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] deger;
        logic        yaz;
        logic [1:0]  sec;
        logic [31:0] pc;
        logic [31:0] bib;
    } bekl_t;

    bekl_t kuyruk[$];
    int vektor = 0;
    int hata = 0;

    task automatic chk(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        vektor++;
        if (gercek !== beklenen) begin
            hata++;
            $display("FAIL %s: got %h expected %h (t=%0t)", ad, gercek, beklenen, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (gecerli_o === 1'b1) begin
            if (kuyruk.size() == 0) begin
                chk("unexpected_gecerli", 32'd1, 32'd0);
            end else begin
                bekl_t e;
                e = kuyruk.pop_front();
                chk("rd_adres_o", {27'b0, rd_adres_o}, {27'b0, e.rd});
                chk("rd_deger_o", rd_deger_o, e.deger);
                chk("yaz_yazmac_o", {31'b0, yaz_yazmac_o}, {31'b0, e.yaz});
                chk("sec_geri_yaz_o", {30'b0, sec_geri_yaz_o}, {30'b0, e.sec});
                chk("pc4_o", program_sayaci_artmis_o, e.pc);
                chk("bib_deger_o", bib_deger_o, e.bib);
            end
        end
    end

    task automatic adim();
        @(posedge clk_i);
        #1;
    endtask

    task automatic surdur(input logic oku, input logic yz, input logic [1:0] boyut,
                          input logic isz, input logic [31:0] adr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic [31:0] deger, input logic yy,
                          input logic [1:0] sec, input logic [31:0] pc);
        gecerli_i = 1'b1; bib_oku_i = oku; bib_yaz_i = yz; bib_boyut_i = boyut;
        bib_isaretsiz_i = isz; bib_adres_i = adr; bib_yaz_veri_i = wdata; rd_adres_i = rd;
        rd_deger_i = deger; yaz_yazmac_i = yy; sec_geri_yaz_i = sec; program_sayaci_artmis_i = pc;
    endtask

    task automatic birak();
        gecerli_i = 1'b0; bib_oku_i = 1'b0; bib_yaz_i = 1'b0;
        bib_adres_i = 32'hFFFF_FFFF; rd_deger_i = 32'h5555_AAAA;
    endtask

    // One instruction end to end; hw/rw are extra cycles before ready/response.
    task automatic issue(input logic oku, input logic yz, input logic [1:0] boyut, input logic isz,
                         input logic [31:0] adr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] deger, input logic yy, input logic [1:0] sec,
                         input logic [31:0] pc, input int hw, input int rw, input logic [31:0] rdata,
                         input logic [31:0] e_adr, input logic [3:0] e_m, input logic [31:0] e_v,
                         input logic [31:0] e_bib);
        int dsay;
        bekl_t e;
        chk("durdur_bosta", {31'b0, durdur_o}, 32'd0);
        e = '{rd: rd, deger: deger, yaz: yy & ~yz, sec: sec, pc: pc, bib: e_bib};
        kuyruk.push_back(e);
        surdur(oku, yz, boyut, isz, adr, wdata, rd, deger, yy, sec, pc);
        adim();
        birak();
        dsay = 0;
        if (oku || yz) begin
            for (int w = 0; w <= hw; w++) begin
                if (durdur_o) dsay++;
                chk("istek", {31'b0, bellek_istek_o}, 32'd1);
                chk("adres", bellek_adres_o, e_adr);
                chk("yaz", {31'b0, bellek_yaz_o}, {31'b0, yz});
                if (yz) begin
                    chk("maske", {28'b0, bellek_maske_o}, {28'b0, e_m});
                    chk("veri", bellek_veri_o, e_v);
                end
                bellek_hazir_i = (w == hw);
                adim();
                bellek_hazir_i = 1'b0;
            end
            chk("istek_dustu", {31'b0, bellek_istek_o}, 32'd0);
            if (oku) begin
                for (int r = 0; r <= rw; r++) begin
                    if (durdur_o) dsay++;
                    chk("bekle_gecerli_yok", {31'b0, gecerli_o}, 32'd0);
                    bellek_yanit_gecerli_i = (r == rw);
                    bellek_yanit_veri_i = (r == rw) ? rdata : 32'h5A5A_5A5A;
                    adim();
                    bellek_yanit_gecerli_i = 1'b0;
                end
            end
            chk("durdur_sayisi", dsay, (hw + 1) + (oku ? rw + 1 : 0));
        end
        chk("gecikme_gecerli", {31'b0, gecerli_o}, 32'd1);
    endtask

    initial begin
        #12;
        chk("rst_gecerli", {31'b0, gecerli_o}, 32'd0);
        chk("rst_durdur", {31'b0, durdur_o}, 32'd0);
        chk("rst_istek", {31'b0, bellek_istek_o}, 32'd0);
        chk("rst_maske", {28'b0, bellek_maske_o}, 32'd0);
        rst_ni = 1'b1;
        adim();

        // ALU op
        issue(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd5, 32'h1234, 1, 2'b00, 32'h104, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("alu_durdur", {31'b0, durdur_o}, 32'd0);
        // sb 0x1003
        issue(0, 1, 2'b00, 0, 32'h1003, 32'h0000_00AB, 5'd7, 32'h1003, 1, 2'b00, 32'h108,
              0, 0, 0, 32'h1000, 4'b1000, 32'hABAB_ABAB, 32'h0);
        // sh 0x1002
        issue(0, 1, 2'b01, 0, 32'h1002, 32'h1234_BEEF, 5'd0, 32'h1002, 0, 2'b00, 32'h10C,
              0, 0, 0, 32'h1000, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        // sw with ready waits
        issue(0, 1, 2'b10, 0, 32'h1000, 32'hDEAD_BEEF, 5'd1, 32'h1000, 1, 2'b00, 32'h110,
              2, 0, 0, 32'h1000, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        // lb / lbu / lh / lhu / lb positive
        issue(1, 0, 2'b00, 0, 32'h2002, 0, 5'd3, 32'h2002, 1, 2'b01, 32'h114,
              0, 0, 32'h0080_0000, 32'h2000, 0, 0, 32'hFFFF_FF80);
        issue(1, 0, 2'b00, 1, 32'h2002, 0, 5'd4, 32'h2002, 1, 2'b01, 32'h118,
              0, 0, 32'h0080_0000, 32'h2000, 0, 0, 32'h0000_0080);
        issue(1, 0, 2'b01, 0, 32'h2002, 0, 5'd6, 32'h2002, 1, 2'b01, 32'h11C,
              0, 0, 32'h8001_0000, 32'h2000, 0, 0, 32'hFFFF_8001);
        issue(1, 0, 2'b01, 1, 32'h2000, 0, 5'd8, 32'h2000, 1, 2'b01, 32'h120,
              0, 0, 32'h1234_8001, 32'h2000, 0, 0, 32'h0000_8001);
        issue(1, 0, 2'b00, 0, 32'h2001, 0, 5'd9, 32'h2001, 1, 2'b01, 32'h124,
              0, 0, 32'h0000_7F00, 32'h2000, 0, 0, 32'h0000_007F);
        // lw: ready low 3 cycles, response one cycle late -> 6 stall cycles
        issue(1, 0, 2'b10, 0, 32'h3000, 0, 5'd10, 32'h3000, 1, 2'b01, 32'h128,
              3, 1, 32'hCAFE_F00D, 32'h3000, 0, 0, 32'hCAFE_F00D);

`ifdef BELLEK_HIZA_HATA_EN
        begin
            bekl_t e;
            e = '{rd: 5'd11, deger: 32'h1002, yaz: 1'b0, sec: 2'b01, pc: 32'h12C, bib: 32'h0};
            kuyruk.push_back(e);
            surdur(1, 0, 2'b10, 0, 32'h1002, 0, 5'd11, 32'h1002, 1, 2'b01, 32'h12C);
            adim();
            birak();
            chk("hiza_istek", {31'b0, bellek_istek_o}, 32'd0);
            chk("hiza_durdur", {31'b0, durdur_o}, 32'd0);
            chk("hiza_hatasi", {31'b0, hiza_hatasi_o}, 32'd1);
            chk("hata_adres", hata_adres_o, 32'h1002);
            chk("hiza_gecerli", {31'b0, gecerli_o}, 32'd1);
            adim();
            chk("hiza_tek_cevrim", {31'b0, hiza_hatasi_o}, 32'd0);
        end
`else
        issue(1, 0, 2'b10, 0, 32'h1002, 0, 5'd11, 32'h1002, 1, 2'b01, 32'h12C,
              0, 0, 32'h0BAD_F00D, 32'h1000, 0, 0, 32'h0BAD_F00D);
`endif

        // reset while waiting for the response: instruction lost
        surdur(1, 0, 2'b10, 0, 32'h4000, 0, 5'd12, 32'h4000, 1, 2'b01, 32'h130);
        adim();
        birak();
        bellek_hazir_i = 1'b1;
        adim();
        bellek_hazir_i = 1'b0;
        chk("bekle_durdur", {31'b0, durdur_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rst2_durdur", {31'b0, durdur_o}, 32'd0);
        chk("rst2_istek", {31'b0, bellek_istek_o}, 32'd0);
        chk("rst2_gecerli", {31'b0, gecerli_o}, 32'd0);
        chk("rst2_rd_deger", rd_deger_o, 32'd0);
        chk("rst2_pc4", program_sayaci_artmis_o, 32'd0);
        chk("rst2_bib", bib_deger_o, 32'd0);
        adim();
        rst_ni = 1'b1;
        adim();
        bellek_yanit_gecerli_i = 1'b1;
        bellek_yanit_veri_i = 32'h1111_2222;
        adim();
        bellek_yanit_gecerli_i = 1'b0;
        chk("yanit_yok_sayildi", {31'b0, gecerli_o}, 32'd0);
        chk("rst2_bosta", {31'b0, durdur_o}, 32'd0);

        issue(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd13, 32'h7777, 1, 2'b10, 32'h134, 0, 0, 0, 0, 0, 0, 32'h0);

        repeat (3) adim();
        chk("kuyruk_bos", kuyruk.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vektor, hata);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
